// File: rtl/pend_arb_pkg.sv
// ---------------------------------------------------------------------------
// pend_arb_pkg
// Shared types and constants for the pending-request round-robin arbiter.
//   arb_state_t : FSM state encoding (IDLE / OFFER / CLEAR / WAIT), 2 bits
//   CNT_W       : width of the WAIT timeout counter (covers TMO up to 15)
//   wrap_add    : (base + off) folded back into 0..w-1, for base < w, off < w
// ---------------------------------------------------------------------------
package pend_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      CLEAR = 2'd2,
      WAIT  = 2'd3
   } arb_state_t;

   localparam int CNT_W = 4;

   function automatic int wrap_add(input int base, input int off, input int w);
      int s;
      s = base + off;
      return (s >= w) ? (s - w) : s;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational wrap-around first-set scan: starting at ptr_i and moving
// upward (W-1 wraps to 0), report the first set bit of req_i.
//   req_i   [W-1:0]  request vector
//   ptr_i   [IW-1:0] scan start position, expected in 0..W-1
//   found_o          at least one request bit is set
//   index_o [IW-1:0] index of the first set bit at/after ptr_i (0 if none)
// W need not be a power of two.
// ---------------------------------------------------------------------------
module rr_pick
   import pend_arb_pkg::*;
#(
   parameter int  W  = 8,
   localparam int IW = $clog2(W)
) (
   input  logic [W-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] index_o
);

   // cand[k] is the request index sitting k places after the pointer.
   logic [IW-1:0] cand [W];
   logic [W-1:0]  hit;

   for (genvar gi = 0; gi < W; gi++) begin : g_rot
      assign cand[gi] = IW'(wrap_add(int'(ptr_i), gi, W));
      assign hit[gi]  = req_i[cand[gi]];
   end

   assign found_o = |hit;

   // Scan from the far end so the smallest offset is the last writer.
   always_comb begin
      index_o = '0;
      for (int k = W - 1; k >= 0; k--) begin
         if (hit[k]) begin
            index_o = cand[k];
         end
      end
   end

endmodule

// File: rtl/pend_arbiter.sv
// ---------------------------------------------------------------------------
// pend_arbiter
// Round-robin arbiter downstream of an edge-set/edge-clear pending latch
// array. Offers one request index at a time over valid/ready, returns a
// one-hot clear pulse on acceptance, then waits (bounded by TMO cycles) for
// the latched bit to drop before arbitrating again.
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_pend  [W-1:0]  latched pending bits
//   o_valid          an index is offered
//   o_index [IW-1:0] offered index (meaningful while o_valid)
//   i_ready          consumer accepts the offer
//   o_clear [W-1:0]  one-hot, one-cycle clear pulse to the latch array
//   o_err            one-cycle pulse when the drop check times out
// All outputs are registered.
// ---------------------------------------------------------------------------
module pend_arbiter
   import pend_arb_pkg::*;
#(
   parameter int  W   = 8,
   parameter int  TMO = 4,
   localparam int IW  = $clog2(W)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [W-1:0]  i_pend,
   output logic          o_valid,
   output logic [IW-1:0] o_index,
   input  logic          i_ready,
   output logic [W-1:0]  o_clear,
   output logic          o_err
);

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [IW-1:0]    index_q, index_d;
   logic [W-1:0]     clear_q, clear_d;
   logic             err_q, err_d;

   logic             pick_found;
   logic [IW-1:0]    pick_index;

   rr_pick #(.W(W)) u_pick (
      .req_i   (i_pend),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .index_o (pick_index)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      index_d = index_q;
      clear_d = '0;   // clear and err are pulses: low unless set below
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               index_d = pick_index;
               valid_d = 1'b1;
               state_d = OFFER;
            end
         end

         OFFER: begin
            // The offer is held regardless of i_pend; only the handshake ends it.
            if (valid_q && i_ready) begin
               valid_d = 1'b0;
               clear_d = {{(W-1){1'b0}}, 1'b1} << index_q;
               ptr_d   = (index_q == IW'(W - 1)) ? '0 : index_q + 1'b1;
               state_d = CLEAR;
            end
         end

         CLEAR: begin
            cnt_d   = '0;
            state_d = WAIT;
         end

         WAIT: begin
            // index_q still names the granted bit after valid drops.
            if (!i_pend[index_q]) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(TMO)) begin
                  // Give up: the bit is assumed re-set by its source and will
                  // come round again once the pointer wraps back to it.
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
         clear_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         index_q <= index_d;
         clear_q <= clear_d;
         err_q   <= err_d;
      end
   end

   assign o_valid = valid_q;
   assign o_index = index_q;
   assign o_clear = clear_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_pend_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pend_arbiter
// Directed bench for pend_arbiter. Instance A uses W=8/TMO=4, instance B
// uses W=5. Each instance drives a small pending-latch model (set pulses
// from the stimulus, cleared by o_clear unless the bit is held).
// ---------------------------------------------------------------------------
module tb_pend_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- instance A: W=8 ----------------
   logic [7:0] pend_a;
   logic [7:0] set_a  = '0;
   logic [7:0] hold_a = '0;
   logic [7:0] clear_a;
   logic       rdy_a  = 1'b0;
   logic       valid_a, err_a;
   logic [2:0] index_a;

   pend_arbiter #(.W(8), .TMO(4)) dut_a (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_pend  (pend_a),
      .o_valid (valid_a),
      .o_index (index_a),
      .i_ready (rdy_a),
      .o_clear (clear_a),
      .o_err   (err_a)
   );

   // ---------------- instance B: W=5 ----------------
   logic [4:0] pend_b;
   logic [4:0] set_b = '0;
   logic [4:0] clear_b;
   logic       rdy_b = 1'b0;
   logic       valid_b, err_b;
   logic [2:0] index_b;

   pend_arbiter #(.W(5), .TMO(4)) dut_b (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_pend  (pend_b),
      .o_valid (valid_b),
      .o_index (index_b),
      .i_ready (rdy_b),
      .o_clear (clear_b),
      .o_err   (err_b)
   );

   // Pending latch models: clear wins over a simultaneous set.
   always @(posedge clk or posedge rst) begin
      if (rst) pend_a <= '0;
      else     pend_a <= (pend_a | set_a) & ~(clear_a & ~hold_a);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) pend_b <= '0;
      else     pend_b <= (pend_b | set_b) & ~clear_b;
   end

   // ---------------- monitors (sample pre-edge values) ----------------
   int cyc     = 0;
   int gq_a[$];
   int gc_a[$];
   int ec_a[$];
   int gq_b[$];
   int gap_a   = 0;
   int oh_a    = 0;
   int zeros_a = 100;

   always @(posedge clk) begin
      if (valid_a && rdy_a) begin
         gq_a.push_back(int'(index_a));
         gc_a.push_back(cyc);
         $display("A grant idx=%0d cyc=%0d", index_a, cyc);
      end
      if (err_a) begin
         ec_a.push_back(cyc);
         $display("A timeout idx=%0d cyc=%0d", index_a, cyc);
      end
      if (clear_a != '0) begin
         if (!$onehot(clear_a)) oh_a <= oh_a + 1;
         if (zeros_a < 3)       gap_a <= gap_a + 1;
         zeros_a <= 0;
      end else begin
         zeros_a <= zeros_a + 1;
      end
      if (valid_b && rdy_b) begin
         gq_b.push_back(int'(index_b));
         $display("B grant idx=%0d cyc=%0d", index_b, cyc);
      end
      cyc <= cyc + 1;
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_valid_a(input int budget);
      int n = 0;
      while (!valid_a && n < budget) begin
         tick();
         n++;
      end
      chk("valid_a_seen", valid_a, 1);
   endtask

   task automatic wait_grants_a(input int cnt, input int budget);
      int n = 0;
      while (gq_a.size() < cnt && n < budget) begin
         tick();
         n++;
      end
      chk("grants_a_seen", gq_a.size() >= cnt, 1);
   endtask

   task automatic wait_grants_b(input int cnt, input int budget);
      int n = 0;
      while (gq_b.size() < cnt && n < budget) begin
         tick();
         n++;
      end
      chk("grants_b_seen", gq_b.size() >= cnt, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int eb;
      int k;

      // ---- reset values ----
      tick();
      tick();
      chk("rst_valid", valid_a, 0);
      chk("rst_clear", clear_a, 0);
      chk("rst_err",   err_a,   0);
      chk("rst_index", index_a, 0);
      rst = 1'b0;
      tick();

      // ---- single request 8'h04 ----
      b = gq_a.size();
      rdy_a = 1'b1;
      set_a = 8'h04;
      tick();
      set_a = '0;
      wait_valid_a(10);
      chk("single_index",     index_a, 2);
      chk("single_clear_pre", clear_a, 0);
      tick();
      chk("single_clear",      clear_a, 8'h04);
      chk("single_valid_drop", valid_a, 0);
      tick();
      chk("single_clear_off", clear_a, 0);
      chk("single_bit_drop",  pend_a,  0);
      tick();
      tick();
      chk("single_idle",  valid_a, 0);
      chk("single_err",   err_a,   0);
      chk("single_grant", gq_a[b], 2);

      // ---- reset mid-OFFER (ptr is 3 here) ----
      rdy_a = 1'b0;
      set_a = 8'h10;
      tick();
      set_a = '0;
      wait_valid_a(10);
      chk("offer_index", index_a, 4);
      #2 rst = 1'b1;
      #1;
      chk("rstoff_valid", valid_a, 0);
      chk("rstoff_clear", clear_a, 0);
      chk("rstoff_err",   err_a,   0);
      chk("rstoff_index", index_a, 0);
      tick();
      rst = 1'b0;

      // ---- backpressure 8'h81, ptr back at 0 ----
      b = gq_a.size();
      set_a = 8'h81;
      tick();
      set_a = '0;
      wait_valid_a(10);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", valid_a, 1);
         chk("bp_index", index_a, 0);
         chk("bp_clear", clear_a, 0);
         tick();
      end
      rdy_a = 1'b1;
      wait_grants_a(b + 2, 30);
      chk("bp_first",  gq_a[b],     0);
      chk("bp_second", gq_a[b + 1], 7);
      repeat (6) tick();

      // ---- reset during the clear pulse ----
      set_a = 8'h20;
      tick();
      set_a = '0;
      k = 0;
      while (clear_a == '0 && k < 20) begin
         tick();
         k++;
      end
      chk("clr_seen", clear_a, 8'h20);
      #2 rst = 1'b1;
      #1;
      chk("rstclr_clear", clear_a, 0);
      tick();
      rst = 1'b0;

      // ---- timeout: bit 3 ignores its clear ----
      b = gq_a.size();
      eb = ec_a.size();
      hold_a = 8'h08;
      set_a = 8'h4A;
      tick();
      set_a = '0;
      wait_grants_a(b + 4, 60);
      rdy_a = 1'b0;
      repeat (10) tick();
      chk("tmo_g0", gq_a[b],     1);
      chk("tmo_g1", gq_a[b + 1], 3);
      chk("tmo_g2", gq_a[b + 2], 6);
      chk("tmo_g3", gq_a[b + 3], 3);
      chk("tmo_err_count", ec_a.size() - eb, 2);
      chk("tmo_err_delay", ec_a[eb] - gc_a[b + 1], 6);
      hold_a = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // ---- all eight pending, ready held high ----
      b = gq_a.size();
      rdy_a = 1'b1;
      set_a = 8'hFF;
      tick();
      set_a = '0;
      wait_grants_a(b + 8, 45);
      for (int i = 0; i < 8; i++) begin
         chk("rr_order", gq_a[b + i], i);
      end
      for (int i = 1; i < 8; i++) begin
         chk("rr_period", gc_a[b + i] - gc_a[b + i - 1], 4);
      end
      repeat (6) tick();
      chk("clear_spacing", gap_a, 0);
      chk("clear_onehot",  oh_a,  0);

      // ---- W=5 wrap: move ptr to 4, then 5'b10001 ----
      rdy_b = 1'b1;
      set_b = 5'b01000;
      tick();
      set_b = '0;
      wait_grants_b(1, 20);
      repeat (5) tick();
      set_b = 5'b10001;
      tick();
      set_b = '0;
      wait_grants_b(3, 30);
      repeat (5) tick();
      set_b = 5'b00011;
      tick();
      set_b = '0;
      wait_grants_b(4, 20);
      repeat (5) tick();
      chk("w5_g0", gq_b[0], 3);
      chk("w5_g1", gq_b[1], 4);
      chk("w5_g2", gq_b[2], 0);
      chk("w5_g3", gq_b[3], 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
